// File: rtl/pixel_array_scanner.sv
// Raster-readout sequencer: walks a ROWS x COLS pixel array and streams samples out through a FIFO.
// Optional region-of-interest scanning is enabled by defining PIXEL_SCAN_ROI_EN.
module pixel_array_scanner #(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_W     = 8,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef PIXEL_SCAN_ROI_EN
    input  logic [ROW_W-1:0]  roi_row0,
    input  logic [ROW_W-1:0]  roi_row1,
    input  logic [COL_W-1:0]  roi_col0,
    input  logic [COL_W-1:0]  roi_col1,
`endif
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              frame_done,
    output logic              read,
    output logic [ROW_W-1:0]  row_addr,
    output logic [COL_W-1:0]  col_addr,
    input  logic [DATA_W-1:0] pix_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = DATA_W + 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_PUSH = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              read_q, read_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];

    logic              start_ok_s;
    logic              accept_s;
    logic [ROW_W-1:0]  load_row_s;
    logic [COL_W-1:0]  load_col_s;
    logic [ROW_W-1:0]  first_row_s;
    logic [ROW_W-1:0]  last_row_s;
    logic [COL_W-1:0]  first_col_s;
    logic [COL_W-1:0]  last_col_s;
    logic              sof_s;
    logic              eol_s;
    logic              last_pix_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              space_s;
    logic [ENT_W-1:0]  head_s;

`ifdef PIXEL_SCAN_ROI_EN
    logic [ROW_W-1:0]  roi_r0_q, roi_r1_q;
    logic [COL_W-1:0]  roi_c0_q, roi_c1_q;

    // Widened compares keep the range check meaningful when ROWS/COLS are powers of two.
    assign start_ok_s  = (roi_row0 <= roi_row1) && (roi_col0 <= roi_col1) &&
                         ({1'b0, roi_row1} < (ROW_W+1)'(ROWS)) &&
                         ({1'b0, roi_col1} < (COL_W+1)'(COLS));
    assign load_row_s  = roi_row0;
    assign load_col_s  = roi_col0;
    assign first_row_s = roi_r0_q;
    assign last_row_s  = roi_r1_q;
    assign first_col_s = roi_c0_q;
    assign last_col_s  = roi_c1_q;

    // Capture the region bounds on an accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            roi_r0_q <= {ROW_W{1'b0}};
            roi_r1_q <= {ROW_W{1'b0}};
            roi_c0_q <= {COL_W{1'b0}};
            roi_c1_q <= {COL_W{1'b0}};
        end else if (accept_s) begin
            roi_r0_q <= roi_row0;
            roi_r1_q <= roi_row1;
            roi_c0_q <= roi_col0;
            roi_c1_q <= roi_col1;
        end
    end
`else
    assign start_ok_s  = 1'b1;
    assign load_row_s  = {ROW_W{1'b0}};
    assign load_col_s  = {COL_W{1'b0}};
    assign first_row_s = {ROW_W{1'b0}};
    assign last_row_s  = ROW_W'(ROWS - 1);
    assign first_col_s = {COL_W{1'b0}};
    assign last_col_s  = COL_W'(COLS - 1);
`endif

    assign accept_s   = (state_q == S_IDLE) && start && start_ok_s && !abort;
    assign sof_s      = (row_q == first_row_s) && (col_q == first_col_s);
    assign eol_s      = (col_q == last_col_s);
    assign last_pix_s = (row_q == last_row_s) && eol_s;

    assign full_s     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign out_valid  = (count_q != {(PTR_W+1){1'b0}});
    assign pop_s      = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign space_s    = !full_s || pop_s;

    // Next-state, address walk and sample capture.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        push_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    row_d   = load_row_s;
                    col_d   = load_col_s;
                    state_d = S_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                cnt_d   = CNT_W'(READ_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    data_d  = pix_data;
                    state_d = S_PUSH;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_PUSH: begin
                if (space_s) begin
                    push_s = 1'b1;
                    if (last_pix_s) begin
                        row_d   = {ROW_W{1'b0}};
                        col_d   = {COL_W{1'b0}};
                        state_d = S_DONE;
                    end else if (eol_s) begin
                        row_d   = row_q + ROW_W'(1);
                        col_d   = first_col_s;
                        state_d = S_ADDR;
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        state_d = S_ADDR;
                    end
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
            row_d   = {ROW_W{1'b0}};
            col_d   = {COL_W{1'b0}};
            push_s  = 1'b0;
        end else begin
            push_s  = push_s;
        end
        read_d = (state_d == S_ADDR) || (state_d == S_WAIT);
        busy_d = read_d || (state_d == S_PUSH);
        done_d = (state_d == S_DONE);
    end

    // FIFO pointer and occupancy update; abort flushes.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (abort) begin
            wr_d    = {PTR_W{1'b0}};
            rd_d    = {PTR_W{1'b0}};
            count_d = {(PTR_W+1){1'b0}};
        end else begin
            wr_d = push_s ? (wr_q + PTR_W'(1)) : wr_q;
            rd_d = pop_s  ? (rd_q + PTR_W'(1)) : rd_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Sequencer and FIFO control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            row_q   <= {ROW_W{1'b0}};
            col_q   <= {COL_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= {PTR_W{1'b0}};
            rd_q    <= {PTR_W{1'b0}};
            count_q <= {(PTR_W+1){1'b0}};
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            read_q  <= read_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; entry layout is {data, sof, eol, eof}.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_q] <= {data_q, sof_s, eol_s, last_pix_s};
        end
    end

    assign head_s     = mem_q[rd_q];
    assign out_data   = out_valid ? head_s[ENT_W-1:3] : {DATA_W{1'b0}};
    assign out_sof    = out_valid ? head_s[2] : 1'b0;
    assign out_eol    = out_valid ? head_s[1] : 1'b0;
    assign out_eof    = out_valid ? head_s[0] : 1'b0;

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign read       = read_q;
    assign row_addr   = row_q;
    assign col_addr   = col_q;

endmodule

// File: tb/tb_pixel_array_scanner.sv
// Directed bench for pixel_array_scanner on a 2x3 array, READ_LAT=2, FIFO_DEPTH=4.
module tb_pixel_array_scanner;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       frame_done;
    logic       read;
    logic [0:0] row_addr;
    logic [1:0] col_addr;
    logic [7:0] pix_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eol;
    logic       out_eof;
`ifdef PIXEL_SCAN_ROI_EN
    logic [0:0] roi_row0 = 1'b0;
    logic [0:0] roi_row1 = 1'b1;
    logic [1:0] roi_col0 = 2'd0;
    logic [1:0] roi_col1 = 2'd2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int read_cnt = 0;
    int done_cnt = 0;
    int addr_err = 0;
    int cyc;
    logic       prev_read = 1'b0;
    logic [2:0] prev_addr = 3'd0;
    logic [10:0] got_q[$];

    // {data, sof, eol, eof} for pixel value row*16+col
    logic [10:0] exp_frame [6] = '{
        {8'h00, 3'b100}, {8'h01, 3'b000}, {8'h02, 3'b010},
        {8'h10, 3'b000}, {8'h11, 3'b000}, {8'h12, 3'b011}
    };

    pixel_array_scanner #(
        .ROWS(2), .COLS(3), .DATA_W(8), .READ_LAT(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef PIXEL_SCAN_ROI_EN
        .roi_row0(roi_row0),
        .roi_row1(roi_row1),
        .roi_col0(roi_col0),
        .roi_col1(roi_col1),
`endif
        .start(start),
        .abort(abort),
        .busy(busy),
        .frame_done(frame_done),
        .read(read),
        .row_addr(row_addr),
        .col_addr(col_addr),
        .pix_data(pix_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sof(out_sof),
        .out_eol(out_eol),
        .out_eof(out_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pix_data = read ? {3'b000, row_addr, 2'b00, col_addr} : 8'hEE;

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) got_q.push_back({out_data, out_sof, out_eol, out_eof});
            if (read) read_cnt++;
            if (frame_done) done_cnt++;
            if (read && prev_read && ({row_addr, col_addr} != prev_addr)) addr_err++;
            prev_read = read;
            prev_addr = {row_addr, col_addr};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        got_q.delete();
        read_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!frame_done && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("done_seen", 32'(frame_done), 32'd1);
    endtask

    task automatic check_frames(input string tag, input int nframes);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(6 * nframes));
        for (int i = 0; i < got_q.size(); i++) begin
            chk($sformatf("%s_entry%0d", tag, i), 32'(got_q[i]), 32'(exp_frame[i % 6]));
        end
        got_q.delete();
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_head", 32'({out_data, out_sof, out_eol, out_eof}), 32'd0);
        chk("rst_addr", 32'({row_addr, col_addr}), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Unstalled frame
        clear();
        pulse_start();
        chk("f1_busy", 32'(busy), 32'd1);
        wait_done(100, cyc);
        chk("f1_latency", 32'(cyc), 32'd24);
        chk("f1_read_cycles", 32'(read_cnt), 32'd18);
        chk("f1_busy_low", 32'(busy), 32'd0);
        repeat (8) tick();
        chk("f1_done_pulses", 32'(done_cnt), 32'd1);
        chk("f1_addr_home", 32'({row_addr, col_addr}), 32'd0);
        check_frames("f1", 1);

        // Backpressure stalls in PUSH after four entries
        out_ready = 1'b0;
        clear();
        pulse_start();
        repeat (40) tick();
        chk("bp_read", 32'(read), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_read_cycles", 32'(read_cnt), 32'd15);
        chk("bp_no_done", 32'(done_cnt), 32'd0);
        out_ready = 1'b1;
        wait_done(100, cyc);
        repeat (8) tick();
        check_frames("bp", 1);

        // Abort after three pushes
        clear();
        pulse_start();
        repeat (12) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_read", 32'(read), 32'd0);
        chk("ab_valid", 32'(out_valid), 32'd0);
        chk("ab_addr", 32'({row_addr, col_addr}), 32'd0);
        repeat (30) tick();
        chk("ab_no_done", 32'(done_cnt), 32'd0);
        chk("ab_entries", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) chk("ab_last", 32'(got_q[2]), 32'(exp_frame[2]));
        clear();
        pulse_start();
        wait_done(100, cyc);
        repeat (8) tick();
        check_frames("post_abort", 1);

        // start while busy is ignored; start during frame_done ignored, next IDLE accepted
        clear();
        pulse_start();
        repeat (5) tick();
        pulse_start();
        repeat (5) tick();
        pulse_start();
        wait_done(100, cyc);
        chk("busy_start_latency", 32'(cyc), 32'd12);
        pulse_start();
        chk("start_in_done", 32'(busy), 32'd0);
        pulse_start();
        chk("start_after_done", 32'(busy), 32'd1);
        wait_done(100, cyc);
        repeat (8) tick();
        chk("two_frame_done", 32'(done_cnt), 32'd2);
        check_frames("two_frames", 2);

        // start and abort together in IDLE
        clear();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        repeat (10) tick();
        chk("sa_read_cycles", 32'(read_cnt), 32'd0);
        chk("sa_entries", 32'(got_q.size()), 32'd0);

        // Asynchronous reset mid-WAIT with entries held in the FIFO
        out_ready = 1'b0;
        clear();
        pulse_start();
        repeat (5) tick();
        chk("ar_pre_read", 32'(read), 32'd1);
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_read", 32'(read), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_valid", 32'(out_valid), 32'd0);
        #3 reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        clear();
        pulse_start();
        wait_done(100, cyc);
        repeat (8) tick();
        check_frames("post_reset", 1);

        chk("addr_stable_during_read", 32'(addr_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
